// File: rtl/fetch_pkg.sv
// Shared types and helpers for the fetch stage: FSM state encoding,
// instruction size and the fetch-address legality check.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        FLUSH,
        HALT
    } fetch_state_t;

    localparam int unsigned INSTR_BYTES = 4;

    // A fetch address is legal when word aligned and the whole word fits in memory.
    function automatic logic is_legal_pc(input logic [31:0] addr, input int unsigned size);
        return (addr[1:0] == 2'b00) && (addr <= (size - INSTR_BYTES));
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory bus: byte address out, registered read data back one cycle later.
interface fetch_unit_if;

    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;

    modport master (output imem_addr, input imem_rdata);
    modport slave  (input imem_addr, output imem_rdata);

endinterface

// File: rtl/fetch_pc_gen.sv
// Combinational next-PC arithmetic, fetch-address mux and legality checks
// feeding the fetch_unit FSM.
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter int unsigned IMEM_BYTES = 128
) (
    input  fetch_state_t state,
    input  logic [31:0]  pc_f,
    input  logic [31:0]  pc_d,
    input  logic         stall,
    input  logic [31:0]  redirect_target,
    output logic [31:0]  pc_f_plus4,
    output logic [31:0]  pc_d_plus4,
    output logic         pc_f_ok,
    output logic         target_ok,
    output logic [31:0]  imem_addr
);

    // Increment, legality and address selection.
    always_comb begin
        pc_f_plus4 = pc_f + INSTR_BYTES;
        pc_d_plus4 = pc_d + INSTR_BYTES;
        pc_f_ok    = is_legal_pc(pc_f, IMEM_BYTES);
        target_ok  = is_legal_pc(redirect_target, IMEM_BYTES);
        // Replay pc_d while a valid RUN word is stalled so imem_rdata stays put.
        // BOOT and FLUSH ignore stall, so they must keep fetching pc_f.
        imem_addr  = (state == RUN && stall) ? pc_d : pc_f;
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: drives the instruction-memory address, pairs each returned word
// with its PC, handles redirects/stalls and halts on an illegal fetch target.
// Optional build macro FETCH_PERF_EN adds the fetch_perf_count output.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0004,
    parameter int unsigned IMEM_BYTES = 128
) (
    input  logic                clk,
    input  logic                resetn,
    fetch_unit_if.master        imem,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_target,
    output logic                out_valid,
    output logic [31:0]         out_instr,
    output logic [31:0]         out_pc,
    output logic [31:0]         out_pc_plus4,
    output logic                fault,
    output logic [31:0]         fault_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]         fetch_perf_count
`endif
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_f_q, pc_f_d;
    logic [31:0]  pc_d_q, pc_d_d;
    logic         fault_q, fault_d;
    logic [31:0]  fault_pc_q, fault_pc_d;

    logic [31:0]  pc_f_plus4;
    logic [31:0]  pc_d_plus4;
    logic         pc_f_ok;
    logic         target_ok;
    logic [31:0]  imem_addr_w;

    fetch_pc_gen #(
        .IMEM_BYTES (IMEM_BYTES)
    ) u_pc_gen (
        .state           (state_q),
        .pc_f            (pc_f_q),
        .pc_d            (pc_d_q),
        .stall           (stall),
        .redirect_target (redirect_target),
        .pc_f_plus4      (pc_f_plus4),
        .pc_d_plus4      (pc_d_plus4),
        .pc_f_ok         (pc_f_ok),
        .target_ok       (target_ok),
        .imem_addr       (imem_addr_w)
    );

    assign imem.imem_addr = imem_addr_w;

    // Next-state logic; priority HALT > redirect > stall > advance.
    always_comb begin
        state_d    = state_q;
        pc_f_d     = pc_f_q;
        pc_d_d     = pc_d_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        unique case (state_q)
            BOOT: begin
                pc_d_d  = pc_f_q;
                pc_f_d  = pc_f_plus4;
                state_d = RUN;
            end
            RUN, FLUSH: begin
                if (redirect_valid) begin
                    if (!target_ok) begin
                        state_d    = HALT;
                        fault_d    = 1'b1;
                        fault_pc_d = redirect_target;
                    end else begin
                        pc_f_d  = redirect_target;
                        state_d = FLUSH;
                    end
                end else if (state_q == FLUSH) begin
                    pc_d_d  = pc_f_q;
                    pc_f_d  = pc_f_plus4;
                    state_d = RUN;
                end else if (!stall) begin
                    if (!pc_f_ok) begin
                        state_d    = HALT;
                        fault_d    = 1'b1;
                        fault_pc_d = pc_f_q;
                    end else begin
                        pc_d_d = pc_f_q;
                        pc_f_d = pc_f_plus4;
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
        endcase
    end

    // Output decode: the word on imem_rdata always belongs to pc_d.
    always_comb begin
        out_valid    = (state_q == RUN) && !redirect_valid;
        out_instr    = imem.imem_rdata;
        out_pc       = pc_d_q;
        out_pc_plus4 = pc_d_plus4;
        fault        = fault_q;
        fault_pc     = fault_pc_q;
    end

    // State and PC registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= BOOT;
            pc_f_q     <= RESET_PC;
            pc_d_q     <= 32'h0;
            fault_q    <= 1'b0;
            fault_pc_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_f_q     <= pc_f_d;
            pc_d_q     <= pc_d_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_q, perf_d;

    // Count accepted instructions; wraps naturally at 2^32.
    always_comb begin
        perf_d = perf_q;
        if (out_valid && !stall) begin
            perf_d = perf_q + 32'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            perf_q <= 32'h0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign fetch_perf_count = perf_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with a 128-byte big-endian registered-read
// memory and a delivered-instruction-stream reference model.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC  = 32'h4;
    localparam int unsigned MEM_SZ  = 128;
    localparam logic [31:0] ADDI    = 32'h00F00093;
    localparam logic [31:0] XORI    = 32'h0FF0C113;

    logic        clk;
    logic        resetn;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic        fault;
    logic [31:0] fault_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_perf_count;
`endif

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC   (RST_PC),
        .IMEM_BYTES (MEM_SZ)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .imem            (bus),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .out_valid       (out_valid),
        .out_instr       (out_instr),
        .out_pc          (out_pc),
        .out_pc_plus4    (out_pc_plus4),
        .fault           (fault),
        .fault_pc        (fault_pc)
`ifdef FETCH_PERF_EN
        ,
        .fetch_perf_count (fetch_perf_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: big-endian bytes, registered read, zero while in reset.
    logic [7:0] mem [MEM_SZ];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a > MEM_SZ - 4) return 32'h0;
        return {mem[a], mem[a + 1], mem[a + 2], mem[a + 3]};
    endfunction

    always @(posedge clk) begin
        bus.imem_rdata <= resetn ? mem_word(bus.imem_addr) : 32'h0;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: which instruction the stage should be presenting.
    bit          m_boot, m_flush, m_halt, m_fault;
    logic [31:0] m_pc, m_fault_pc, m_perf;
    int          m_halt_cycles;

    logic        obs_valid;
    logic [31:0] obs_pc, obs_instr, obs_plus4, obs_addr, obs_fault_pc;
    logic        obs_fault;

    function automatic bit legal(input logic [31:0] a);
        return (a % 4 == 0) && (a <= MEM_SZ - 4);
    endfunction

    task automatic do_reset();
        resetn          = 1'b0;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'h0, out_valid}, 32'h0);
        check("rst_fault", {31'h0, fault}, 32'h0);
        check("rst_fault_pc", fault_pc, 32'h0);
        check("rst_imem_addr", bus.imem_addr, RST_PC);
        m_boot        = 1;
        m_flush       = 0;
        m_halt        = 0;
        m_fault       = 0;
        m_pc          = RST_PC;
        m_fault_pc    = 0;
        m_perf        = 0;
        m_halt_cycles = 0;
        resetn        = 1'b1;
    endtask

    // One clock: drive inputs, compare at the falling edge, then advance the model.
    task automatic step(input logic s, input logic r, input logic [31:0] t);
        bit exp_valid;
        stall           = s;
        redirect_valid  = r;
        redirect_target = t;
        @(negedge clk);
        obs_valid    = out_valid;
        obs_pc       = out_pc;
        obs_instr    = out_instr;
        obs_plus4    = out_pc_plus4;
        obs_addr     = bus.imem_addr;
        obs_fault    = fault;
        obs_fault_pc = fault_pc;
        exp_valid = !m_halt && !m_boot && !m_flush && !r;
        check("out_valid", {31'h0, out_valid}, {31'h0, exp_valid});
        if (exp_valid) begin
            check("out_pc", out_pc, m_pc);
            check("out_instr", out_instr, mem_word(m_pc));
            check("out_pc_plus4", out_pc_plus4, m_pc + 4);
        end
        if (!m_halt && !m_boot && !m_flush) begin
            check("imem_addr", bus.imem_addr, s ? m_pc : m_pc + 4);
        end
        check("fault", {31'h0, fault}, {31'h0, m_fault});
        check("fault_pc", fault_pc, m_fault_pc);
`ifdef FETCH_PERF_EN
        check("perf", fetch_perf_count, m_perf);
`endif
        @(posedge clk);
        #1;
        if (exp_valid && !s) m_perf = m_perf + 1;
        if (m_halt) begin
            m_halt_cycles++;
        end else if (m_boot) begin
            m_boot = 0;
        end else if (r) begin
            if (!legal(t)) begin
                m_halt = 1; m_fault = 1; m_fault_pc = t;
            end else begin
                m_flush = 1; m_pc = t;
            end
        end else if (m_flush) begin
            m_flush = 0;
        end else if (!s) begin
            if (!legal(m_pc + 4)) begin
                m_halt = 1; m_fault = 1; m_fault_pc = m_pc + 4;
            end else begin
                m_pc = m_pc + 4;
            end
        end
    endtask

    initial begin
        bit          found;
        logic [31:0] t;
        int          r;

        for (int i = 0; i < MEM_SZ; i++) mem[i] = 8'($urandom);
        {mem[4], mem[5], mem[6], mem[7]}    = ADDI;
        {mem[8], mem[9], mem[10], mem[11]}  = XORI;

        do_reset();
        step(0, 0, 0);
        check("boot_valid", {31'h0, obs_valid}, 32'h0);
        step(0, 0, 0);
        check("first_pc", obs_pc, 32'd4);
        check("first_instr", obs_instr, ADDI);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0);
            check("stall_pc", obs_pc, 32'd8);
            check("stall_addr", obs_addr, 32'd8);
            check("stall_instr", obs_instr, XORI);
        end
        step(0, 0, 0);
        check("release_pc", obs_pc, 32'd8);
        step(0, 0, 0);
        check("after_stall_pc", obs_pc, 32'd12);
        step(0, 1, 32'd28);
        check("redir_squash", {31'h0, obs_valid}, 32'h0);
        step(0, 0, 0);
        check("flush_bubble", {31'h0, obs_valid}, 32'h0);
        step(0, 0, 0);
        check("target_pc", obs_pc, 32'd28);
        check("target_plus4", obs_plus4, 32'd32);

        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(0, 0, 0);
            if (obs_valid && obs_pc == 32'd124) found = 1;
        end
        check("reach_124", {31'h0, found}, 32'h1);
        step(0, 0, 0);
        check("end_fault", {31'h0, obs_fault}, 32'h1);
        check("end_fault_pc", obs_fault_pc, 32'd128);
        check("end_valid", {31'h0, obs_valid}, 32'h0);

        do_reset();
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 1, 32'd30);
        for (int i = 0; i < 3; i++) begin
            step(i == 1, i == 2, 32'd8);
            check("mis_fault", {31'h0, obs_fault}, 32'h1);
            check("mis_fault_pc", obs_fault_pc, 32'd30);
            check("mis_valid", {31'h0, obs_valid}, 32'h0);
        end

`ifdef FETCH_PERF_EN
        do_reset();
        step(0, 0, 0);
        for (int i = 0; i < 12; i++) step(i == 3 || i == 7, 0, 0);
        check("perf_10", fetch_perf_count, 32'd10);
`endif

        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ((m_halt && m_halt_cycles > 3) || $urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                r = $urandom_range(0, 15);
                if (r == 0)      t = 32'($urandom_range(0, 127));
                else if (r == 1) t = 32'(MEM_SZ + 4 * $urandom_range(0, 64));
                else             t = 32'(4 * $urandom_range(0, 31));
                step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, t);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
